// File: rtl/event_serializer_pkg.sv
// Shared definitions for the event serializer: record defaults, marker byte, FSM encoding.
package event_serializer_pkg;

  localparam int         REC_BYTES_DEFAULT = 6;
  localparam logic [7:0] MARKER_BYTE       = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/event_serializer_sync_fifo.sv
// Record FIFO with fall-through head and occupancy count.
// A write offered while full is refused even if a pop happens in the same cycle.
module event_serializer_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_reg == LVL_W'(DEPTH));
  assign empty_o = (level_reg == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign level_o = level_reg;
  // Head is visible combinationally so a pop can load it in the same cycle.
  assign data_o  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/event_serializer.sv
// Buffers tag records and serializes them MSB-byte-first onto the out_mux writer port.
// Optional in-band loss markers are enabled by defining LOST_MARKER_EN.
module event_serializer
  import event_serializer_pkg::*;
#(
  parameter int REC_BYTES  = REC_BYTES_DEFAULT,
  parameter int FIFO_DEPTH = 16,
  parameter int LOST_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [8*REC_BYTES-1:0]      rec_i,
  input  logic                        rec_valid_i,
  input  logic                        capture_en_i,
  input  logic                        lost_clr_i,
  output logic [LOST_W-1:0]           lost_count_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [7:0]                  omux_data_o,
  output logic                        omux_req_o,
  input  logic                        omux_sel_i
);

  localparam int REC_W  = 8 * REC_BYTES;
  localparam int BIDX_W = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(REC_BYTES - 1);

  logic [REC_W-1:0]  push_data;
  logic [REC_W-1:0]  head_data;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_attempt;

  ser_state_t        state_reg;
  logic [REC_W-1:0]  shreg_reg;
  logic [BIDX_W-1:0] byte_idx_reg;
  logic [LOST_W-1:0] lost_count_reg;

  assign wr_attempt = rec_valid_i && capture_en_i;

`ifdef LOST_MARKER_EN
  logic              lost_pending_reg;
  logic [LOST_W-1:0] lost_since_reg;
  logic              marker_push;
  logic [REC_W-1:0]  marker_rec;

  // While a loss is pending every record is refused, so the marker lands in stream order.
  always_comb begin
    marker_rec                 = '0;
    marker_rec[REC_W-1 -: 8]   = MARKER_BYTE;
    marker_rec[LOST_W-1:0]     = lost_since_reg;
    marker_push                = lost_pending_reg && !fifo_full && !rec_valid_i;
    drop                       = wr_attempt && (fifo_full || lost_pending_reg);
    push                       = marker_push || (wr_attempt && !fifo_full && !lost_pending_reg);
    push_data                  = marker_push ? marker_rec : rec_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lost_pending_reg <= 1'b0;
      lost_since_reg   <= '0;
    end else if (marker_push) begin
      lost_pending_reg <= 1'b0;
      lost_since_reg   <= '0;
    end else if (drop) begin
      lost_pending_reg <= 1'b1;
      if (lost_since_reg != '1) lost_since_reg <= lost_since_reg + LOST_W'(1);
    end
  end
`else
  always_comb begin
    drop      = wr_attempt && fifo_full;
    push      = wr_attempt && !fifo_full;
    push_data = rec_i;
  end
`endif

  assign pop = (state_reg == ST_IDLE) && !fifo_empty;

  event_serializer_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= '0;
      byte_idx_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shreg_reg    <= head_data;
            byte_idx_reg <= '0;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (omux_sel_i) begin
            if (byte_idx_reg == LAST_IDX) begin
              state_reg <= ST_IDLE;
            end else begin
              shreg_reg    <= shreg_reg << 8;
              byte_idx_reg <= byte_idx_reg + BIDX_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Request drops in the cycle the last byte is taken so out_mux re-arbitrates between records.
  assign omux_req_o  = (state_reg == ST_SEND) && !(omux_sel_i && (byte_idx_reg == LAST_IDX));
  assign omux_data_o = (state_reg == ST_SEND) ? shreg_reg[REC_W-1 -: 8] : 8'h00;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lost_count_reg <= '0;
    end else if (lost_clr_i) begin
      lost_count_reg <= '0;
    end else if (drop && (lost_count_reg != '1)) begin
      lost_count_reg <= lost_count_reg + LOST_W'(1);
    end
  end

  assign lost_count_o = lost_count_reg;

endmodule

// File: tb/tb_event_serializer.sv
// Directed bench for event_serializer; define LOST_MARKER_EN to also exercise loss markers.
module tb_event_serializer;

  localparam int REC_BYTES  = 6;
  localparam int FIFO_DEPTH = 16;
  localparam int LOST_W     = 8;  // narrow counter so saturation is reached in a few hundred cycles

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [47:0] rec_i;
  logic        rec_valid_i;
  logic        capture_en_i;
  logic        lost_clr_i;
  logic [7:0]  lost_count_o;
  logic [4:0]  fifo_level_o;
  logic [7:0]  omux_data_o;
  logic        omux_req_o;
  logic        omux_sel_i;

  int n_checks = 0;
  int n_fail   = 0;

  event_serializer #(
    .REC_BYTES  (REC_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LOST_W     (LOST_W)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rec_i        (rec_i),
    .rec_valid_i  (rec_valid_i),
    .capture_en_i (capture_en_i),
    .lost_clr_i   (lost_clr_i),
    .lost_count_o (lost_count_o),
    .fifo_level_o (fifo_level_o),
    .omux_data_o  (omux_data_o),
    .omux_req_o   (omux_req_o),
    .omux_sel_i   (omux_sel_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [47:0] make_rec(input int k);
    return {8'h3C, 16'(k), 8'hA5, 8'h5A, 8'(k)};
  endfunction

  task automatic do_reset();
    reset_i      = 1'b1;
    rec_valid_i  = 1'b0;
    rec_i        = '0;
    capture_en_i = 1'b1;
    lost_clr_i   = 1'b0;
    omux_sel_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Offers n consecutive records, one per rising edge; returns at the negedge after the last.
  task automatic push_burst(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      rec_valid_i = 1'b1;
      rec_i       = make_rec(base + k);
    end
    @(negedge clk_i);
    rec_valid_i = 1'b0;
  endtask

  // Waits for a request, holds it for 'hold' cycles, then accepts one byte.
  task automatic get_byte(input int hold, output logic [7:0] b, output logic req_at_sel,
                          output bit ok);
    ok = 1'b0;
    b = '0;
    req_at_sel = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (omux_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (hold) @(negedge clk_i);
      omux_sel_i = 1'b1;
      #1;
      b          = omux_data_o;
      req_at_sel = omux_req_o;
      @(posedge clk_i);
      #1;
      omux_sel_i = 1'b0;
    end
  endtask

  task automatic get_record(output logic [47:0] r, output bit ok);
    logic [7:0] b;
    logic       rq;
    bit         okb;
    r  = '0;
    ok = 1'b1;
    for (int i = 0; i < REC_BYTES; i++) begin
      get_byte(0, b, rq, okb);
      if (!okb) begin
        ok = 1'b0;
        break;
      end
      r = {r[39:0], b};
    end
    $display("rx record %h ok=%0d", r, ok);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 4;
    if (omux_req_o !== 1'b0)    begin n_fail++; $display("FAIL reset_req: got %b expected 0", omux_req_o); end
    if (omux_data_o !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h expected 00", omux_data_o); end
    if (lost_count_o !== 8'h00) begin n_fail++; $display("FAIL reset_lost: got %h expected 00", lost_count_o); end
    if (fifo_level_o !== 5'd0)  begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
  endtask

  task automatic test_capture_off();
    do_reset();
    capture_en_i = 1'b0;
    push_burst(5, 0);
    @(negedge clk_i);
    n_checks += 3;
    if (fifo_level_o !== 5'd0)  begin n_fail++; $display("FAIL capoff_level: got %0d expected 0", fifo_level_o); end
    if (lost_count_o !== 8'h00) begin n_fail++; $display("FAIL capoff_lost: got %h expected 00", lost_count_o); end
    if (omux_req_o !== 1'b0)    begin n_fail++; $display("FAIL capoff_req: got %b expected 0", omux_req_o); end
    capture_en_i = 1'b1;
  endtask

  task automatic test_single();
    logic [47:0] rec;
    logic [7:0]  exp_b;
    logic [7:0]  b;
    logic        rq;
    bit          ok;
    do_reset();
    rec = 48'hA1B2C3D4E5F6;
    @(negedge clk_i);
    rec_valid_i = 1'b1;
    rec_i       = rec;
    @(negedge clk_i);
    rec_valid_i = 1'b0;
    // Written at edge N: stored, not yet popped.
    n_checks += 2;
    if (fifo_level_o !== 5'd1) begin n_fail++; $display("FAIL single_level_n: got %0d expected 1", fifo_level_o); end
    if (omux_req_o !== 1'b0)   begin n_fail++; $display("FAIL single_req_n: got %b expected 0", omux_req_o); end
    @(negedge clk_i);
    n_checks += 3;
    if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL single_level_n1: got %0d expected 0", fifo_level_o); end
    if (omux_req_o !== 1'b1)   begin n_fail++; $display("FAIL single_req_n1: got %b expected 1", omux_req_o); end
    if (omux_data_o !== 8'hA1) begin n_fail++; $display("FAIL single_data_n1: got %h expected a1", omux_data_o); end
    for (int i = 0; i < REC_BYTES; i++) begin
      exp_b = rec[47 - 8*i -: 8];
      get_byte(3, b, rq, ok);
      n_checks += 2;
      if (!ok || b !== exp_b) begin
        n_fail++; $display("FAIL single_byte%0d: got %h ok=%0d expected %h", i, b, ok, exp_b);
      end
      if (rq !== (i != REC_BYTES - 1)) begin
        n_fail++; $display("FAIL single_req_at_sel%0d: got %b expected %b", i, rq, (i != REC_BYTES - 1));
      end
    end
    @(negedge clk_i);
    n_checks += 1;
    if (omux_req_o !== 1'b0) begin n_fail++; $display("FAIL single_req_after: got %b expected 0", omux_req_o); end
  endtask

  // One record goes straight into the serializer, 16 fill the FIFO, the 18th is dropped.
  task automatic test_overflow();
    logic [47:0] r;
    bit          ok;
    do_reset();
    push_burst(18, 0);
    n_checks += 2;
    if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d expected 16", fifo_level_o); end
    if (lost_count_o !== 8'd1)  begin n_fail++; $display("FAIL ovf_lost: got %0d expected 1", lost_count_o); end
    for (int k = 0; k < 17; k++) begin
      get_record(r, ok);
      n_checks++;
      if (!ok || r !== make_rec(k)) begin
        n_fail++; $display("FAIL ovf_rec%0d: got %h ok=%0d expected %h", k, r, ok, make_rec(k));
      end
    end
    repeat (3) @(negedge clk_i);
    n_checks += 2;
    if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL ovf_level_end: got %0d expected 0", fifo_level_o); end
    if (omux_req_o !== 1'b0)   begin n_fail++; $display("FAIL ovf_req_end: got %b expected 0", omux_req_o); end
  endtask

  task automatic test_reset_mid();
    logic [47:0] r;
    logic [7:0]  b;
    logic        rq;
    bit          ok;
    do_reset();
    push_burst(2, 40);
    get_byte(0, b, rq, ok);
    get_byte(0, b, rq, ok);
    @(posedge clk_i);
    #3;
    n_checks += 2;
    if (omux_req_o !== 1'b1)   begin n_fail++; $display("FAIL mid_req_before: got %b expected 1", omux_req_o); end
    if (fifo_level_o !== 5'd1) begin n_fail++; $display("FAIL mid_level_before: got %0d expected 1", fifo_level_o); end
    reset_i = 1'b1;
    #1;
    n_checks += 3;
    if (omux_req_o !== 1'b0)   begin n_fail++; $display("FAIL mid_req_async: got %b expected 0", omux_req_o); end
    if (omux_data_o !== 8'h00) begin n_fail++; $display("FAIL mid_data_async: got %h expected 00", omux_data_o); end
    if (fifo_level_o !== 5'd0) begin n_fail++; $display("FAIL mid_level_async: got %0d expected 0", fifo_level_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    push_burst(1, 50);
    get_record(r, ok);
    n_checks++;
    if (!ok || r !== make_rec(50)) begin
      n_fail++; $display("FAIL mid_next_rec: got %h ok=%0d expected %h", r, ok, make_rec(50));
    end
  endtask

  task automatic test_saturation();
    do_reset();
    push_burst(17 + 255, 0);
    n_checks++;
    if (lost_count_o !== 8'hFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ff", lost_count_o); end
    push_burst(3, 300);
    n_checks++;
    if (lost_count_o !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ff", lost_count_o); end
    @(negedge clk_i);
    rec_valid_i = 1'b1;
    rec_i       = make_rec(400);
    lost_clr_i  = 1'b1;
    @(negedge clk_i);
    rec_valid_i = 1'b0;
    lost_clr_i  = 1'b0;
    n_checks++;
    if (lost_count_o !== 8'h00) begin n_fail++; $display("FAIL sat_clr_wins: got %h expected 00", lost_count_o); end
    push_burst(1, 401);
    n_checks++;
    if (lost_count_o !== 8'h01) begin n_fail++; $display("FAIL sat_after_clr: got %h expected 01", lost_count_o); end
  endtask

`ifdef LOST_MARKER_EN
  task automatic test_marker();
    logic [47:0] r;
    bit          ok;
    do_reset();
    push_burst(20, 0);
    @(negedge clk_i);
    n_checks += 2;
    if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL mk_level: got %0d expected 16", fifo_level_o); end
    if (lost_count_o !== 8'd3)  begin n_fail++; $display("FAIL mk_lost: got %0d expected 3", lost_count_o); end
    for (int k = 0; k < 17; k++) begin
      get_record(r, ok);
      n_checks++;
      if (!ok || r !== make_rec(k)) begin
        n_fail++; $display("FAIL mk_rec%0d: got %h ok=%0d expected %h", k, r, ok, make_rec(k));
      end
    end
    get_record(r, ok);
    n_checks++;
    if (!ok || r !== 48'hFF00_0000_0003) begin
      n_fail++; $display("FAIL mk_marker: got %h ok=%0d expected ff0000000003", r, ok);
    end
    // Second episode: a record offered while pending is dropped even with a free slot.
    push_burst(18, 100);
    rec_valid_i  = 1'b1;
    capture_en_i = 1'b0;
    get_record(r, ok);
    @(negedge clk_i);
    n_checks += 3;
    if (!ok || r !== make_rec(100)) begin
      n_fail++; $display("FAIL mk_ep2_rec: got %h ok=%0d expected %h", r, ok, make_rec(100));
    end
    if (fifo_level_o !== 5'd15) begin n_fail++; $display("FAIL mk_ep2_level: got %0d expected 15", fifo_level_o); end
    if (lost_count_o !== 8'd4)  begin n_fail++; $display("FAIL mk_ep2_lost: got %0d expected 4", lost_count_o); end
    capture_en_i = 1'b1;
    @(negedge clk_i);
    capture_en_i = 1'b0;
    rec_valid_i  = 1'b0;
    n_checks += 2;
    if (lost_count_o !== 8'd5)  begin n_fail++; $display("FAIL mk_pend_drop: got %0d expected 5", lost_count_o); end
    if (fifo_level_o !== 5'd15) begin n_fail++; $display("FAIL mk_pend_level: got %0d expected 15", fifo_level_o); end
    @(negedge clk_i);
    n_checks++;
    if (fifo_level_o !== 5'd16) begin n_fail++; $display("FAIL mk_marker2_push: got %0d expected 16", fifo_level_o); end
    capture_en_i = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_capture_off();
    test_single();
    test_overflow();
    test_reset_mid();
    test_saturation();
`ifdef LOST_MARKER_EN
    test_marker();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
